fpu_arbiter: RTL

Two-requester front end for the shared single-issue FPU (32-bit format: sign, 6-bit exponent, 25-bit mantissa, bias 31). It accepts operand pairs from two clients over valid/ready handshakes and arbitrates between them round-robin. It holds the granted operands stable on the FPU inputs for the FPU's fixed latency, then captures the result and status and returns them on a shared response channel tagged with the requester id. Exactly one operation is in flight at a time.

---
 rtl/fpu_pkg.sv | 15 +
 rtl/rr_arb2.sv | 22 ++
 rtl/fpu_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU word format constants and arbiter state encoding
package fpu_pkg;
   localparam int FP_W     = 32;
   localparam int EXP_W    = 6;
   localparam int MAN_W    = 25;
   localparam int FP_BIAS  = 31;
   localparam int STATUS_W = 4;
   localparam int CNT_W    = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin grant
module rr_arb2
   import fpu_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       grant,
   output logic       grant_valid
);

   always_comb begin
      grant       = 1'b0;
      grant_valid = |valid;
      unique case (valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - two-client front end for the shared single-issue FPU
// Holds one operation in flight: accept, wait FPU_LAT cycles, return tagged result.
module fpu_arbiter
   import fpu_pkg::*;
#(
   parameter int FPU_LAT = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [FP_W-1:0]     req0_op_a,
   input  logic [FP_W-1:0]     req0_op_b,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [FP_W-1:0]     req1_op_a,
   input  logic [FP_W-1:0]     req1_op_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_id,
   output logic [FP_W-1:0]     rsp_data,
   output logic [STATUS_W-1:0] rsp_status,
   output logic [FP_W-1:0]     fpu_op_a,
   output logic [FP_W-1:0]     fpu_op_b,
   input  logic [FP_W-1:0]     fpu_data,
   input  logic [STATUS_W-1:0] fpu_status,
   output logic                busy
);

   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(FPU_LAT);

   arb_state_t          state_q;
   logic                last_grant_q;
   logic                id_q;
   logic                rsp_valid_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [FP_W-1:0]     op_a_q;
   logic [FP_W-1:0]     op_b_q;
   logic [FP_W-1:0]     rsp_data_q;
   logic [STATUS_W-1:0] rsp_status_q;
   logic                grant;
   logic                grant_valid;
   logic                idle_d;

   rr_arb2 u_rr_arb2 (
      .valid       ({req1_valid, req0_valid}),
      .last_grant  (last_grant_q),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Readies are gated by reset so nothing appears accepted in a reset cycle.
   assign idle_d     = (state_q == IDLE) && !reset;
   assign req0_ready = idle_d && grant_valid && !grant;
   assign req1_ready = idle_d && grant_valid && grant;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         cnt_q        <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req0_valid && req0_ready) begin
                  op_a_q       <= req0_op_a;
                  op_b_q       <= req0_op_b;
                  id_q         <= 1'b0;
                  last_grant_q <= 1'b0;
                  cnt_q        <= LAT_INIT;
                  state_q      <= WAIT;
               end else if (req1_valid && req1_ready) begin
                  op_a_q       <= req1_op_a;
                  op_b_q       <= req1_op_b;
                  id_q         <= 1'b1;
                  last_grant_q <= 1'b1;
                  cnt_q        <= LAT_INIT;
                  state_q      <= WAIT;
               end
            end
            WAIT: begin
               // The counter parks at 1 on capture and is reloaded on the next accept.
               if (cnt_q == CNT_W'(1)) begin
                  rsp_data_q   <= fpu_data;
                  rsp_status_q <= fpu_status;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = id_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_status = rsp_status_q;
   assign fpu_op_a   = op_a_q;
   assign fpu_op_b   = op_b_q;
   assign busy       = (state_q != IDLE);

endmodule
